// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the MEM-stage data memory controller.
//   - FSM state encoding (IDLE / ACCESS / DONE)
//   - alignment-check helpers for word and halfword accesses
//   - halfword-select constants used by the load formatter
package mips_mem_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // address[1] selects which halfword of the little-endian word is loaded
  localparam logic HALF_SEL_LO = 1'b0;
  localparam logic HALF_SEL_HI = 1'b1;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  // Halfword accesses must sit on a 2-byte boundary.
  function automatic logic half_aligned(input logic [31:0] addr);
    return (addr[0] == 1'b0);
  endfunction

endpackage

// File: rtl/load_formatter.sv
// load_formatter: combinational load-data formatting for LW / LH / LHU.
// Ports:
//   rdata        in  32  raw word returned by data memory
//   addr1        in  1   byte-address bit 1 (selects upper/lower halfword)
//   loadFullWord in  1   1 = LW, 0 = halfword load
//   loadSigned   in  1   1 = sign-extend halfword (LH), 0 = zero-extend (LHU)
//   result       out 32  formatted load value
module load_formatter
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic        addr1,
  input  logic        loadFullWord,
  input  logic        loadSigned,
  output logic [31:0] result
);

  logic [15:0] half_s;

  // Pick the addressed halfword, then widen it according to the load type.
  always_comb begin
    half_s = 16'h0000;
    result = 32'h0000_0000;
    if (addr1 == HALF_SEL_HI) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    if (loadFullWord) begin
      result = rdata;
    end else if (loadSigned) begin
      result = {{16{half_s[15]}}, half_s};
    end else begin
      result = {16'h0000, half_s};
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: sequences MEM-stage loads/stores over a req/ready handshake
// to a variable-latency data memory, stalling the pipeline while in flight.
// Ports:
//   clk, resetN                 clock (rising edge), async active-low reset
//   memRead, memWrite           decoded load / store request (store wins)
//   loadFullWord, loadSigned    load type: LW, LH (signed), LHU
//   address, writeData          byte address and store data from the pipeline
//   stall                       freeze pipeline up to MEM (combinational)
//   loadResult, loadValid       formatted load data + one-cycle completion pulse
//   misaligned, busError        one-cycle error pulses
//   memReq, memWe, memAddr,
//   memWData                    request to data memory (held during ACCESS)
//   memRData, memReady          response from data memory
module data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        loadFullWord,
  input  logic        loadSigned,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        stall,
  output logic [31:0] loadResult,
  output logic        loadValid,
  output logic        misaligned,
  output logic        busError,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memReady
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_store_r;
  logic             full_r;
  logic             signed_r;
  logic             addr1_r;
  logic             mem_req_r;
  logic             mem_we_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic [31:0]      load_result_r;
  logic             load_valid_r;
  logic             misaligned_r;
  logic             bus_error_r;

  logic             access_s;
  logic             aligned_s;
  logic             accept_s;
  logic             reject_s;
  logic             timeout_s;
  logic [31:0]      fmt_result_s;

  // Request decode: a store is always a full word, so it uses the word check
  // even if loadFullWord happens to be low.
  always_comb begin
    access_s  = memRead | memWrite;
    aligned_s = 1'b0;
    if (memWrite | loadFullWord) begin
      aligned_s = word_aligned(address);
    end else begin
      aligned_s = half_aligned(address);
    end
    accept_s  = (state_r == ST_IDLE) & access_s & aligned_s;
    reject_s  = (state_r == ST_IDLE) & access_s & ~aligned_s;
    timeout_s = (cnt_r == CNT_LAST);
  end

  // Stall must rise in the accept cycle itself, so it is combinational; it is
  // gated by resetN so that it is low for the whole reset window.
  always_comb begin
    stall = resetN & (accept_s | (state_r == ST_ACCESS));
  end

  load_formatter u_load_formatter (
    .rdata        (memRData),
    .addr1        (addr1_r),
    .loadFullWord (full_r),
    .loadSigned   (signed_r),
    .result       (fmt_result_s)
  );

  // Access FSM, handshake registers and registered status pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      is_store_r    <= 1'b0;
      full_r        <= 1'b0;
      signed_r      <= 1'b0;
      addr1_r       <= 1'b0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= 32'h0000_0000;
      mem_wdata_r   <= 32'h0000_0000;
      load_result_r <= 32'h0000_0000;
      load_valid_r  <= 1'b0;
      misaligned_r  <= 1'b0;
      bus_error_r   <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless set below.
      load_valid_r <= 1'b0;
      misaligned_r <= 1'b0;
      bus_error_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            is_store_r  <= memWrite;
            full_r      <= loadFullWord;
            signed_r    <= loadSigned;
            addr1_r     <= address[1];
            mem_req_r   <= 1'b1;
            mem_we_r    <= memWrite;
            mem_addr_r  <= {address[31:2], 2'b00};
            mem_wdata_r <= writeData;
            cnt_r       <= '0;
            state_r     <= ST_ACCESS;
          end else if (reject_s) begin
            misaligned_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // Ready wins over a coincident timeout.
          if (memReady) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_DONE;
            if (!is_store_r) begin
              load_valid_r  <= 1'b1;
              load_result_r <= fmt_result_s;
            end else begin
              load_valid_r <= 1'b0;
            end
          end else if (timeout_s) begin
            mem_req_r     <= 1'b0;
            bus_error_r   <= 1'b1;
            load_result_r <= 32'h0000_0000;
            state_r       <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          // Requests seen here belong to the retiring instruction; ignore them.
          state_r <= ST_IDLE;
        end
        default: begin
          mem_req_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign loadResult = load_result_r;
  assign loadValid  = load_valid_r;
  assign misaligned = misaligned_r;
  assign busError   = bus_error_r;
  assign memReq     = mem_req_r;
  assign memWe      = mem_we_r;
  assign memAddr    = mem_addr_r;
  assign memWData   = mem_wdata_r;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Sequences every data-memory access issued by the MEM stage of the MIPS datapath: accepts decoded load/store control (memRead, memWrite, loadFullWord, loadSigned) plus address/store data, and runs a request/ready handshake to a variable-latency data memory. Stalls the pipeline while the access is in flight and formats load data for LW/LH/LHU. Flags misaligned accesses and bus timeouts. Sits between the control unit outputs and the data memory port; the writeback mux consumes loadResult.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in ACCESS waiting for memReady before a bus error (>=1)
CNT_W, 5, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
resetN  in  1  asynchronous active-low reset
memRead  in  1  load requested this cycle (from control unit)
memWrite  in  1  store requested this cycle (SW, always full word)
loadFullWord  in  1  1 = LW, 0 = halfword load
loadSigned  in  1  halfword sign-extend (LH) vs zero-extend (LHU)
address  in  32  byte address from ALU
writeData  in  32  store data
stall  out  1  freeze PC and pipeline registers up to MEM stage
loadResult  out  32  formatted load data, valid when loadValid
loadValid  out  1  one-cycle pulse, load completed
misaligned  out  1  one-cycle pulse, access rejected for alignment
busError  out  1  one-cycle pulse, access timed out
memReq  out  1  request to data memory
memWe  out  1  1 = write request
memAddr  out  32  word-aligned address (bits[1:0] = 0)
memWData  out  32  store data to memory
memRData  in  32  read data, valid with memReady
memReady  in  1  memory completes current request

Behaviour:
- Clocking: one clock clk, rising edge; reset resetN is asynchronous, active-low. Reset forces state IDLE, counter 0, and all outputs 0 (memReq, memWe, memAddr, memWData, loadResult, loadValid, misaligned, busError, stall). Reset mid-access drops memReq immediately; no completion pulse follows.
- States: IDLE, ACCESS, DONE.
- IDLE: access = memRead | memWrite. If both are asserted, the store wins and the load is ignored.
  - Alignment: word access needs address[1:0]==0; halfword needs address[0]==0.
  - Misaligned access: misaligned pulses 1 next cycle, no memory request, stall stays 0, state stays IDLE.
  - Aligned access: stall=1 combinationally in the same cycle. Latch type, address[1] and writeData. Next cycle: memReq=1, memWe=memWrite, memAddr={address[31:2],2'b00}, counter=0, go ACCESS.
  - No access: stall=0.
- ACCESS: memReq held 1 with stable memAddr/memWe/memWData; stall=1.
  - memReady=1: capture memRData, go DONE, memReq=0 next cycle.
  - Otherwise counter increments. At counter==TIMEOUT_CYCLES-1 without memReady, go DONE with the error flag set and memReq=0 next cycle.
  - memReady in the same cycle as the timeout edge counts as success.
- DONE (exactly one cycle): stall=0; the pipeline advances at the end of this cycle.
  - Successful load: loadValid=1 and loadResult formatted.
  - Store: no loadValid.
  - Timeout: busError=1, loadResult=0, loadValid=0.
  - Always returns to IDLE. Requests present during DONE are ignored, since they belong to the instruction being retired.
- Load formatting (little-endian):
  - LW: loadResult=rdata.
  - Halfword: h = addr[1] ? rdata[31:16] : rdata[15:0]; loadResult = loadSigned ? {{16{h[15]}},h} : {16'b0,h}.
- Latency: minimum 3 cycles from an accepted request to DONE (accept, ACCESS with immediate ready, DONE). The pipeline stalls for 2 cycles.
- memReady outside ACCESS is ignored.

Decomposition:
- Package mips_mem_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), alignment-check functions, halfword-select constants.
- One sub-module, load_formatter: combinational; inputs rdata, addr1, loadFullWord, loadSigned; output 32-bit result.

Test Plan:
- LW addr 0x100, memReady on first ACCESS cycle, rdata 0xDEADBEEF -> memAddr 0x100, memWe 0, stall high 2 cycles, loadValid with loadResult 0xDEADBEEF.
- LH addr 0x102, rdata 0x8001_1234 -> loadResult 0xFFFF8001. Same with LHU -> 0x00008001. LH addr 0x100 -> 0x00001234.
- SW addr 0x204, writeData 0xCAFEF00D, memReady after 3 wait cycles -> memWe 1, memWData 0xCAFEF00D held stable, stall 5 cycles total, no loadValid.
- LW addr 0x101, then LH addr 0x103 -> misaligned pulse for each, memReq never asserted, stall 0.
- LW with memReady never asserted, TIMEOUT_CYCLES=16 -> busError pulse after 16 ACCESS cycles, loadResult 0, memReq deasserts.
- resetN low during ACCESS -> memReq/stall 0 immediately. After release, new LW completes normally; memRead and memWrite together -> write performed.
